// File: rtl/driver_bus_master.sv
// rtl/driver_bus_master.sv - register-bus initiator turning host command bursts into slave strobes
// Writes stream one beat per clock; reads keep at most one access outstanding.
module driver_bus_master #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ADDR_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        cmd_incr,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_wr,
  output logic [31:0] slave_addr,
  output logic        slave_rd,
  output logic        slave_wr,
  output logic [31:0] slave_data_in,
  input  logic [31:0] slave_data_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BEAT  = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RSP      = 3'd4,
    WR_DONE  = 3'd5
  } state_e;

  localparam logic [31:0] STEP = 32'(ADDR_STEP);
  localparam logic [2:0]  LAT  = 3'(RD_LATENCY);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        incr_q, incr_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [31:0] slave_addr_q, slave_addr_d;
  logic [31:0] slave_data_q, slave_data_d;
  logic        slave_rd_q, slave_rd_d;
  logic        slave_wr_q, slave_wr_d;
  logic [31:0] addr_next;

  assign addr_next = incr_q ? addr_q + STEP : addr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      incr_q       <= 1'b0;
      lat_cnt_q    <= '0;
      rsp_data_q   <= '0;
      slave_addr_q <= '0;
      slave_data_q <= '0;
      slave_rd_q   <= 1'b0;
      slave_wr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      incr_q       <= incr_d;
      lat_cnt_q    <= lat_cnt_d;
      rsp_data_q   <= rsp_data_d;
      slave_addr_q <= slave_addr_d;
      slave_data_q <= slave_data_d;
      slave_rd_q   <= slave_rd_d;
      slave_wr_q   <= slave_wr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    incr_d       = incr_q;
    lat_cnt_d    = lat_cnt_q;
    rsp_data_d   = rsp_data_q;
    slave_addr_d = slave_addr_q;
    slave_data_d = slave_data_q;
    slave_rd_d   = 1'b0;
    slave_wr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d     = cmd_addr;
          len_d      = cmd_len;
          incr_d     = cmd_incr;
          beat_cnt_d = 8'd0;
          state_d    = cmd_wr ? WR_BEAT : RD_ISSUE;
        end
      end
      WR_BEAT: begin
        if (wdata_valid) begin
          slave_wr_d   = 1'b1;
          slave_addr_d = addr_q;
          slave_data_d = wdata;
          addr_d       = addr_next;
          if (beat_cnt_q == len_q) state_d = WR_DONE;
          else                     beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      RD_ISSUE: begin
        lat_cnt_d = 3'd1;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_cnt_q == LAT) begin
          rsp_data_d = slave_data_out;
          state_d    = RSP;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          if (beat_cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            addr_d     = addr_next;
            state_d    = RD_ISSUE;
          end
        end
      end
      WR_DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The read strobe and its address are registered together on entry to RD_ISSUE
    if (state_d == RD_ISSUE) begin
      slave_rd_d   = 1'b1;
      slave_addr_d = addr_d;
    end
  end

  always_comb begin
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    rsp_valid   = 1'b0;
    rsp_last    = 1'b0;
    rsp_wr      = 1'b0;
    rsp_data    = '0;
    busy        = (state_q != IDLE);
    unique case (state_q)
      IDLE:    cmd_ready = 1'b1;
      WR_BEAT: wdata_ready = 1'b1;
      RSP: begin
        rsp_valid = 1'b1;
        rsp_last  = (beat_cnt_q == len_q);
        rsp_data  = rsp_data_q;
      end
      WR_DONE: begin
        rsp_valid = 1'b1;
        rsp_wr    = 1'b1;
        rsp_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign slave_addr    = slave_addr_q;
  assign slave_data_in = slave_data_q;
  assign slave_rd      = slave_rd_q;
  assign slave_wr      = slave_wr_q;

endmodule

// File: tb/tb_driver_bus_master.sv
// tb/tb_driver_bus_master.sv - table-driven, hand-written and randomized checks for driver_bus_master
module tb_driver_bus_master;
  localparam int unsigned RD_LATENCY = 1;
  localparam int unsigned ADDR_STEP  = 4;
  localparam int          MAX_WAIT   = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cmd_valid, cmd_ready, cmd_wr, cmd_incr;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_wr;
  logic [31:0] rsp_data;
  logic [31:0] slave_addr, slave_data_in;
  logic        slave_rd, slave_wr, busy;
  logic [31:0] slave_data_out = 32'd0;

  driver_bus_master #(.RD_LATENCY(RD_LATENCY), .ADDR_STEP(ADDR_STEP)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_incr(cmd_incr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_wr(rsp_wr),
    .slave_addr(slave_addr), .slave_rd(slave_rd), .slave_wr(slave_wr),
    .slave_data_in(slave_data_in), .slave_data_out(slave_data_out), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor-counter register file: contents are a fixed function of the address
  function automatic logic [31:0] mon_cnt(input logic [31:0] a);
    return (a ^ 32'hC0DE_0104) + {a[7:0], a[31:8]};
  endfunction

  always @(posedge clk) if (slave_rd) slave_data_out <= mon_cnt(slave_addr);

  typedef struct { logic [31:0] addr; logic [31:0] data; int t; } wr_ev_t;
  typedef struct { logic [31:0] data; logic last; logic wr; } rsp_ev_t;
  wr_ev_t      wr_obs[$];
  logic [31:0] rd_obs[$];
  rsp_ev_t     rsp_obs[$];
  int          wr_hs_t[$];

  always @(negedge clk) begin
    if (reset) begin
      if (slave_wr) wr_obs.push_back('{slave_addr, slave_data_in, cyc});
      if (slave_rd) rd_obs.push_back(slave_addr);
      if (rsp_valid && rsp_ready) rsp_obs.push_back('{rsp_data, rsp_last, rsp_wr});
      if (slave_rd || slave_wr) check("strobe_excl", 32'(slave_rd & slave_wr), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    wr_obs.delete(); rd_obs.delete(); rsp_obs.delete(); wr_hs_t.delete();
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] len, input logic incr);
    int w;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_incr = incr;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < MAX_WAIT) begin
      tick();
      @(negedge clk);
      w++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_wr = 1'($urandom); cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_incr = 1'($urandom);
  endtask

  task automatic send_wdata(input logic [7:0] len, input logic [31:0] base, input int gap_min, input int gap_max);
    int w;
    for (int i = 0; i <= int'(len); i++) begin
      wdata_valid = 1'b0;
      wdata = $urandom;
      repeat ($urandom_range(gap_max, gap_min)) tick();
      wdata_valid = 1'b1;
      wdata = base + 32'(i);
      w = 0;
      @(negedge clk);
      while (!wdata_ready && w < MAX_WAIT) begin
        tick();
        @(negedge clk);
        w++;
      end
      if (!wdata_ready) begin
        check("wdata_accept", 32'(wdata_ready), 32'd1);
        break;
      end
      wr_hs_t.push_back(cyc);
      tick();
    end
    wdata_valid = 1'b0;
    wdata = $urandom;
  endtask

  task automatic collect_rsp(input int ready_pct);
    bit done = 1'b0;
    for (int w = 0; w < MAX_WAIT && !done; w++) begin
      rsp_ready = (int'($urandom_range(99, 0)) < ready_pct);
      @(negedge clk);
      done = rsp_valid && rsp_ready && rsp_last;
      tick();
    end
    rsp_ready = 1'b0;
    check("rsp_done", 32'(done), 32'd1);
  endtask

  // Expected traffic derived directly from the burst rules: beat i sits at addr + i*step (mod 2^32)
  task automatic compare_model(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                               input logic incr, input logic [31:0] base);
    logic [31:0] a;
    int n;
    n = int'(len) + 1;
    if (wr) begin
      check("wr_count", 32'(wr_obs.size()), 32'(n));
      check("rd_count_on_wr", 32'(rd_obs.size()), 32'd0);
      check("wr_rsp_count", 32'(rsp_obs.size()), 32'd1);
      for (int i = 0; i < n && i < wr_obs.size(); i++) begin
        a = addr + (incr ? 32'(i * int'(ADDR_STEP)) : 32'd0);
        check("wr_addr", wr_obs[i].addr, a);
        check("wr_data", wr_obs[i].data, base + 32'(i));
        if (i < wr_hs_t.size()) check("wr_timing", 32'(wr_obs[i].t), 32'(wr_hs_t[i] + 1));
      end
      if (rsp_obs.size() > 0) begin
        check("wr_rsp_wr", 32'(rsp_obs[0].wr), 32'd1);
        check("wr_rsp_last", 32'(rsp_obs[0].last), 32'd1);
        check("wr_rsp_data", rsp_obs[0].data, 32'd0);
      end
    end else begin
      check("rd_count", 32'(rd_obs.size()), 32'(n));
      check("wr_count_on_rd", 32'(wr_obs.size()), 32'd0);
      check("rd_rsp_count", 32'(rsp_obs.size()), 32'(n));
      for (int i = 0; i < n && i < rd_obs.size() && i < rsp_obs.size(); i++) begin
        a = addr + (incr ? 32'(i * int'(ADDR_STEP)) : 32'd0);
        check("rd_addr", rd_obs[i], a);
        check("rd_data", rsp_obs[i].data, mon_cnt(a));
        check("rd_last", 32'(rsp_obs[i].last), 32'(i == n - 1));
        check("rd_rsp_wr", 32'(rsp_obs[i].wr), 32'd0);
      end
    end
    clear_obs();
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        incr;
    logic [31:0] wbase;
    int          gap_min, gap_max, ready_pct;
    logic [31:0] exp_last_addr;
    int          exp_strobes, exp_rsp_beats;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_rd, t_v, nrd;
    logic [31:0] d0, a;
    logic wr, incr;
    logic [7:0] len;
    int rd_before;

    vecs[0] = '{1'b1, 32'h0000_0000, 8'd2,   1'b0, 32'h0000_000A, 0, 0, 100, 32'h0000_0000, 3,   1};
    vecs[1] = '{1'b1, 32'hFFFF_FFF8, 8'd2,   1'b1, 32'h0000_1000, 2, 2, 100, 32'h0000_0000, 3,   1};
    vecs[2] = '{1'b0, 32'h0001_1000, 8'd15,  1'b1, 32'h0,         0, 0, 100, 32'h0001_103C, 16, 16};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 8'd1,   1'b1, 32'h0,         0, 0, 60,  32'h0000_0000, 2,   2};
    vecs[4] = '{1'b1, 32'h0000_0020, 8'd255, 1'b1, 32'h5000_0000, 0, 1, 50,  32'h0000_041C, 256, 1};
    vecs[5] = '{1'b0, 32'h0000_0040, 8'd4,   1'b0, 32'h0,         0, 0, 70,  32'h0000_0040, 5,   5};

    reset = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_incr = 1'b0;
    wdata_valid = 1'b0; wdata = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_flags", {29'd0, rsp_last, rsp_wr, 1'b0}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_strobes", {30'd0, slave_rd, slave_wr}, 32'd0);
    check("rst_slave_addr", slave_addr, 32'd0);
    check("rst_slave_data", slave_data_in, 32'd0);
    reset = 1'b1;
    tick();

    foreach (vecs[k]) begin
      issue(vecs[k].wr, vecs[k].addr, vecs[k].len, vecs[k].incr);
      if (vecs[k].wr) send_wdata(vecs[k].len, vecs[k].wbase, vecs[k].gap_min, vecs[k].gap_max);
      collect_rsp(vecs[k].ready_pct);
      repeat (2) tick();
      if (vecs[k].wr) begin
        check("tbl_strobes", 32'(wr_obs.size()), 32'(vecs[k].exp_strobes));
        if (wr_obs.size() > 0) begin
          check("tbl_last_addr", wr_obs[wr_obs.size()-1].addr, vecs[k].exp_last_addr);
          if (vecs[k].gap_max == 0)
            check("tbl_back_to_back", 32'(wr_obs[wr_obs.size()-1].t - wr_obs[0].t), 32'(vecs[k].exp_strobes - 1));
        end
      end else begin
        check("tbl_strobes", 32'(rd_obs.size()), 32'(vecs[k].exp_strobes));
        if (rd_obs.size() > 0) check("tbl_last_addr", rd_obs[rd_obs.size()-1], vecs[k].exp_last_addr);
      end
      check("tbl_rsp_beats", 32'(rsp_obs.size()), 32'(vecs[k].exp_rsp_beats));
      compare_model(vecs[k].wr, vecs[k].addr, vecs[k].len, vecs[k].incr, vecs[k].wbase);
    end

    // Read latency: strobe at T, response valid at T+2 with one cycle of slave latency
    issue(1'b0, 32'h0000_0104, 8'd0, 1'b0);
    t_rd = -1; t_v = -1;
    for (int k = 0; k < 20 && t_v < 0; k++) begin
      @(negedge clk);
      if (slave_rd) t_rd = cyc;
      if (rsp_valid) begin
        t_v = cyc;
        check("lat_rsp_data", rsp_data, mon_cnt(32'h0000_0104));
      end
    end
    check("lat_cycles", 32'(t_v - t_rd), 32'd2);
    tick();
    collect_rsp(100);
    repeat (2) tick();
    compare_model(1'b0, 32'h0000_0104, 8'd0, 1'b0, 32'd0);

    // Backpressure mid-burst: no new read while the response is held
    issue(1'b0, 32'h0000_0200, 8'd3, 1'b1);
    t_v = -1;
    for (int k = 0; k < 20 && t_v < 0; k++) begin
      @(negedge clk);
      if (rsp_valid) t_v = cyc;
    end
    check("bp_rsp_seen", 32'(t_v >= 0), 32'd1);
    d0 = rsp_data;
    rd_before = rd_obs.size();
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_stable", rsp_data, d0);
      check("bp_no_rd", 32'(slave_rd), 32'd0);
      tick();
    end
    check("bp_rd_count", 32'(rd_obs.size()), 32'(rd_before));
    collect_rsp(100);
    repeat (2) tick();
    compare_model(1'b0, 32'h0000_0200, 8'd3, 1'b1, 32'd0);

    // Reset at the third beat of an eight-beat read
    issue(1'b0, 32'h0000_0300, 8'd7, 1'b1);
    rsp_ready = 1'b1;
    nrd = 0;
    for (int k = 0; k < 100 && nrd < 3; k++) begin
      @(negedge clk);
      if (slave_rd) nrd++;
    end
    check("mid_rst_reached", 32'(nrd), 32'd3);
    reset = 1'b0;
    tick();
    check("mid_rst_strobes", {30'd0, slave_rd, slave_wr}, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
    clear_obs();
    reset = 1'b1;
    repeat (10) tick();
    check("post_rst_rd", 32'(rd_obs.size()), 32'd0);
    check("post_rst_wr", 32'(wr_obs.size()), 32'd0);
    check("post_rst_rsp", 32'(rsp_obs.size()), 32'd0);
    clear_obs();

    // Randomized bursts against the arithmetic model
    for (int r = 0; r < 25; r++) begin
      wr   = 1'($urandom);
      incr = 1'($urandom);
      len  = 8'($urandom_range(12, 0));
      a    = ($urandom_range(1, 0) == 1) ? (32'hFFFF_FFE8 + 32'($urandom_range(5, 0) * 4)) : $urandom;
      d0   = $urandom;
      issue(wr, a, len, incr);
      if (wr) send_wdata(len, d0, 0, int'($urandom_range(3, 0)));
      collect_rsp(int'($urandom_range(100, 30)));
      repeat (2) tick();
      compare_model(wr, a, len, incr, d0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
